// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics types, constants and vertex_sequencer state encoding
package gfx_pkg;

   // One vertex or pose position: three IEEE-754 single-precision floats
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } vec3_t;

   localparam logic [31:0] FLOAT_ONE     = 32'h3f80_0000;
   localparam int          VERTEX_WORD_W = 96;

   // Frame sequencer states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_POSE_START,
      ST_POSE_WAIT,
      ST_FETCH,
      ST_FETCH_WAIT,
      ST_XFORM_START,
      ST_XFORM_WAIT,
      ST_EMIT,
      ST_DONE
   } seq_state_t;

   // Vertex memory word layout is {x, y, z} with x in the top bits
   function automatic vec3_t unpack_vertex(input logic [VERTEX_WORD_W-1:0] word);
      vec3_t v;
      v.x = word[95:64];
      v.y = word[63:32];
      v.z = word[31:0];
      return v;
   endfunction

   function automatic logic [VERTEX_WORD_W-1:0] pack_vertex(input vec3_t v);
      return {v.x, v.y, v.z};
   endfunction

endpackage

// File: rtl/vertex_sequencer.sv
// rtl/vertex_sequencer.sv - per-frame pose update and vertex streaming through mvp_matrix
module vertex_sequencer
   import gfx_pkg::*;
#(
   parameter int VERT_AW = 10
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_start,
   input  logic [VERT_AW:0]   vertex_count,
   input  logic [31:0]        roll,
   input  logic [31:0]        pitch,
   input  logic [31:0]        yaw,
   input  logic [31:0]        cam_x,
   input  logic [31:0]        cam_y,
   input  logic [31:0]        cam_z,
   output logic [VERT_AW-1:0] vert_addr,
   input  logic [95:0]        vert_data,
   output logic               mvp_start,
   output logic               mvp_update,
   output logic [31:0]        mvp_roll,
   output logic [31:0]        mvp_pitch,
   output logic [31:0]        mvp_yaw,
   output logic [31:0]        mvp_x,
   output logic [31:0]        mvp_y,
   output logic [31:0]        mvp_z,
   input  logic               mvp_done,
   input  logic [31:0]        mvp_ox,
   input  logic [31:0]        mvp_oy,
   input  logic [31:0]        mvp_oz,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_x,
   output logic [31:0]        out_y,
   output logic [31:0]        out_z,
   output logic [VERT_AW-1:0] out_index,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_overrun
);

   // Largest vertex count a frame may request: the whole vertex memory
   localparam logic [VERT_AW:0] MAX_COUNT = {1'b1, {VERT_AW{1'b0}}};
   localparam logic [VERT_AW:0] ONE_IDX   = {{VERT_AW{1'b0}}, 1'b1};

   seq_state_t         state;
   logic [VERT_AW:0]   count_q;
   logic [VERT_AW-1:0] index_q;
   logic [VERT_AW:0]   next_index;
   vec3_t              xform_in;

   // One wider than the index so the last vertex of a full memory compares correctly
   assign next_index = {1'b0, index_q} + ONE_IDX;

   assign vert_addr = index_q;
   assign mvp_x     = xform_in.x;
   assign mvp_y     = xform_in.y;
   assign mvp_z     = xform_in.z;
   assign busy      = (state != ST_IDLE);

   // Frame FSM; start/update/done/overrun are registered one-cycle pulses, and
   // xform_in holds the camera during the pose pass and the vertex during a transform pass
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         count_q       <= '0;
         index_q       <= '0;
         xform_in      <= '0;
         mvp_roll      <= '0;
         mvp_pitch     <= '0;
         mvp_yaw       <= '0;
         mvp_start     <= 1'b0;
         mvp_update    <= 1'b0;
         out_valid     <= 1'b0;
         out_x         <= '0;
         out_y         <= '0;
         out_z         <= '0;
         out_index     <= '0;
         frame_done    <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         mvp_start     <= 1'b0;
         mvp_update    <= 1'b0;
         frame_done    <= 1'b0;
         frame_overrun <= 1'b0;

         // A new frame request while a frame is in flight is dropped and flagged
         if (frame_start && (state != ST_IDLE)) begin
            frame_overrun <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  mvp_roll   <= roll;
                  mvp_pitch  <= pitch;
                  mvp_yaw    <= yaw;
                  xform_in   <= '{x: cam_x, y: cam_y, z: cam_z};
                  count_q    <= (vertex_count > MAX_COUNT) ? MAX_COUNT : vertex_count;
                  index_q    <= '0;
                  mvp_start  <= 1'b1;
                  mvp_update <= 1'b1;
                  state      <= ST_POSE_START;
               end
            end
            ST_POSE_START: begin
               state <= ST_POSE_WAIT;
            end
            ST_POSE_WAIT: begin
               if (mvp_done) begin
                  if (count_q != '0) begin
                     state <= ST_FETCH;
                  end else begin
                     frame_done <= 1'b1;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_FETCH: begin
               state <= ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
               xform_in  <= unpack_vertex(vert_data);
               mvp_start <= 1'b1;
               state     <= ST_XFORM_START;
            end
            ST_XFORM_START: begin
               state <= ST_XFORM_WAIT;
            end
            ST_XFORM_WAIT: begin
               if (mvp_done) begin
                  out_x     <= mvp_ox;
                  out_y     <= mvp_oy;
                  out_z     <= mvp_oz;
                  out_index <= index_q;
                  out_valid <= 1'b1;
                  state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  index_q   <= next_index[VERT_AW-1:0];
                  if (next_index == count_q) begin
                     frame_done <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vertex_sequencer.sv
// tb/tb_vertex_sequencer.sv - scoreboard bench for vertex_sequencer with a fixed-latency mvp stub
`timescale 1ns/1ps
module tb_vertex_sequencer;
   import gfx_pkg::*;

   localparam int VERT_AW = 10;
   localparam int LAT     = 10;
   localparam int TIMEOUT = 20000;

   typedef struct packed {
      logic [95:0]        v;
      logic [VERT_AW-1:0] idx;
   } exp_out_t;

   logic               clock = 1'b0;
   logic               reset;
   logic               frame_start;
   logic [VERT_AW:0]   vertex_count;
   logic [31:0]        roll, pitch, yaw, cam_x, cam_y, cam_z;
   logic [VERT_AW-1:0] vert_addr;
   logic [95:0]        vert_data;
   logic               mvp_start, mvp_update, mvp_done;
   logic [31:0]        mvp_roll, mvp_pitch, mvp_yaw, mvp_x, mvp_y, mvp_z;
   logic [31:0]        mvp_ox, mvp_oy, mvp_oz;
   logic               out_valid, out_ready;
   logic [31:0]        out_x, out_y, out_z;
   logic [VERT_AW-1:0] out_index;
   logic               busy, frame_done, frame_overrun;

   always #5 clock = ~clock;

   vertex_sequencer #(.VERT_AW(VERT_AW)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .vertex_count(vertex_count),
      .roll(roll), .pitch(pitch), .yaw(yaw), .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
      .vert_addr(vert_addr), .vert_data(vert_data),
      .mvp_start(mvp_start), .mvp_update(mvp_update),
      .mvp_roll(mvp_roll), .mvp_pitch(mvp_pitch), .mvp_yaw(mvp_yaw),
      .mvp_x(mvp_x), .mvp_y(mvp_y), .mvp_z(mvp_z),
      .mvp_done(mvp_done), .mvp_ox(mvp_ox), .mvp_oy(mvp_oy), .mvp_oz(mvp_oz),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_index(out_index),
      .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
   );

   // Vertex memory: one-cycle read latency, 8 entries aliased across the address space
   logic [95:0] mem [0:7];
   always @(posedge clock) vert_data <= mem[vert_addr[2:0]];

   // mvp_matrix stub: done drops for LAT-1 cycles after start, inputs sampled mid-pass, identity output
   int unsigned stub_cnt;
   logic        in_pass;
   logic [31:0] sx, sy, sz;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         stub_cnt <= 0;
         in_pass  <= 1'b0;
         sx <= '0; sy <= '0; sz <= '0;
      end else if (mvp_start) begin
         stub_cnt <= LAT - 1;
         in_pass  <= 1'b1;
      end else begin
         if (stub_cnt == 5) begin
            sx <= mvp_x; sy <= mvp_y; sz <= mvp_z;
         end
         if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
         else               in_pass  <= 1'b0;
      end
   end
   assign mvp_done = (stub_cnt == 0);
   assign mvp_ox   = sx;
   assign mvp_oy   = sy;
   assign mvp_oz   = sz;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard state shared between stimulus and monitor
   exp_out_t    exp_q[$];
   exp_out_t    e_pop;
   logic [95:0] exp_pose = '0;
   logic [95:0] exp_cam  = '0;
   logic [95:0] exp_mx   = '0;
   int          exp_len = 0, exp_starts = 0, exp_ovr = 0;
   int          vk = 0, bcnt = 0, starts = 0, ovr = 0, frames_done = 0;
   logic        held_valid = 1'b0;
   logic [105:0] held = '0;
   int          stall_left = 0;
   int          stall_idx  = 0;

   // Monitor: checks mvp operands, pose, output hold, output stream and per-frame totals
   always @(negedge clock) begin
      if (reset) begin
         vk = 0; bcnt = 0; starts = 0; ovr = 0; held_valid = 1'b0;
      end else begin
         if (mvp_start) begin
            starts++;
            if (mvp_update) exp_mx = exp_cam;
            else begin
               exp_mx = mem[vk % 8];
               vk++;
            end
         end
         if (mvp_start || in_pass) check("mvp_xyz", {mvp_x, mvp_y, mvp_z}, exp_mx);
         if (busy) begin
            bcnt++;
            check("mvp_pose", {mvp_roll, mvp_pitch, mvp_yaw}, exp_pose);
         end
         if (frame_overrun) ovr++;
         if (held_valid) check("out_hold", {out_valid, out_x, out_y, out_z, out_index}, {1'b1, held});
         held_valid = out_valid && !out_ready;
         held       = {out_x, out_y, out_z, out_index};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL out_unexpected: got index %0d expected no output", out_index);
            end else begin
               e_pop = exp_q.pop_front();
               check("out_vertex", {out_x, out_y, out_z, out_index}, {e_pop.v, e_pop.idx});
            end
         end
         if (frame_done) begin
            check("frame_len",    bcnt,         exp_len);
            check("mvp_starts",   starts,       exp_starts);
            check("overrun_cnt",  ovr,          exp_ovr);
            check("pending_outs", exp_q.size(), 0);
            bcnt = 0; starts = 0; ovr = 0; vk = 0;
            frames_done++;
         end
      end
   end

   // Sink: ready high except for a programmed stall on one vertex index
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         if (out_valid && (out_index == stall_idx[VERT_AW-1:0]) && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   task automatic start_frame(input int n, input int nsat, input logic [95:0] pose, input logic [95:0] cam,
                              input int len, input int ovr_cnt);
      @(negedge clock);
      exp_pose   = pose;
      exp_cam    = cam;
      exp_len    = len;
      exp_starts = 1 + nsat;
      exp_ovr    = ovr_cnt;
      for (int i = 0; i < nsat; i++) exp_q.push_back('{v: mem[i % 8], idx: 10'(i)});
      {roll, pitch, yaw}    = pose;
      {cam_x, cam_y, cam_z} = cam;
      vertex_count = 11'(n);
      frame_start  = 1'b1;
      @(negedge clock);
      frame_start  = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      int f0 = frames_done;
      int k  = 0;
      while (frames_done == f0 && k < TIMEOUT) begin
         @(negedge clock);
         k++;
      end
      check(name, frames_done - f0, 1);
   endtask

   // Waits for the transform pass of vertex pass number pass_no to be in its wait phase
   task automatic wait_xform(input int pass_no, input string name);
      int k = 0;
      while (!(vk >= pass_no && in_pass && !mvp_start) && k < 500) begin
         @(negedge clock);
         k++;
      end
      check(name, (vk >= pass_no && in_pass), 1);
   endtask

   initial begin
      mem[0] = {32'h3f80_0000, 32'h4000_0000, 32'h4040_0000};
      mem[1] = {32'h4080_0000, 32'h40a0_0000, 32'h40c0_0000};
      mem[2] = {32'h40e0_0000, 32'h4100_0000, 32'h4110_0000};
      for (int k = 3; k < 8; k++)
         mem[k] = {32'h4120_0000 + 32'(k), 32'hc130_0000 + 32'(k), 32'h4140_0000 + 32'(k)};
      reset = 1'b1; frame_start = 1'b0; vertex_count = '0;
      roll = '0; pitch = '0; yaw = '0; cam_x = '0; cam_y = '0; cam_z = '0;

      // Reset state
      #12;
      check("rst_ctrl", {out_valid, busy, frame_done, frame_overrun, mvp_start, mvp_update}, 0);
      check("rst_out",  {out_x, out_y, out_z}, 0);
      check("rst_mvp",  {mvp_x, mvp_y, mvp_z}, 0);
      check("rst_pose", {mvp_roll, mvp_pitch, mvp_yaw}, 0);
      check("rst_idx",  {vert_addr, out_index}, 0);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("idle_busy", busy, 0);

      // Empty frame: pose pass only, 1+10+1 busy cycles
      start_frame(0, 0, {FLOAT_ONE, 32'h0, 32'h0}, {32'h4000_0000, 32'h4040_0000, 32'h4080_0000}, 12, 0);
      wait_frame("done_count0");

      // Three vertices, always-ready sink: 1+10+3*14+1
      start_frame(3, 3, {32'h3e80_0000, 32'h3f00_0000, 32'hbf00_0000}, {32'h4120_0000, 32'hc120_0000, 32'h4248_0000}, 54, 0);
      wait_frame("done_count3");

      // Five-cycle stall on vertex 1
      stall_idx = 1; stall_left = 5;
      start_frame(3, 3, {32'h3f00_0000, 32'h3e00_0000, 32'h3d00_0000}, {32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000}, 59, 0);
      wait_frame("done_stall");
      check("stall_used", stall_left, 0);

      // New frame request during a transform pass with a different pose
      start_frame(3, 3, {32'h4000_0000, 32'h4040_0000, 32'h4080_0000}, {32'h4100_0000, 32'h4110_0000, 32'h4120_0000}, 54, 1);
      wait_xform(1, "reach_xform_ovr");
      {roll, pitch, yaw}    = {32'hdead_0001, 32'hdead_0002, 32'hdead_0003};
      {cam_x, cam_y, cam_z} = {32'hbeef_0001, 32'hbeef_0002, 32'hbeef_0003};
      vertex_count = 11'd1;
      frame_start  = 1'b1;
      @(negedge clock);
      frame_start  = 1'b0;
      wait_frame("done_overrun");

      // Oversized count saturates to the full 1024-entry memory
      start_frame(2047, 1024, {32'h3c00_0000, 32'h3c80_0000, 32'h3d00_0000}, {32'h0, 32'h0, 32'h3f80_0000}, 1 + 10 + 1024 * 14 + 1, 0);
      wait_frame("done_saturate");

      // Asynchronous reset in the middle of the second transform pass
      start_frame(3, 3, {32'h4040_0000, 32'h4040_0000, 32'h4040_0000}, {32'h4080_0000, 32'h4080_0000, 32'h4080_0000}, 54, 0);
      wait_xform(2, "reach_xform_rst");
      #2 reset = 1'b1;
      #1;
      check("arst_ctrl", {out_valid, busy, frame_done, frame_overrun, mvp_start, mvp_update}, 0);
      check("arst_out",  {out_x, out_y, out_z, out_index}, 0);
      check("arst_mvp",  {mvp_x, mvp_y, mvp_z, vert_addr}, 0);
      check("arst_pose", {mvp_roll, mvp_pitch, mvp_yaw}, 0);
      exp_q.delete();
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Clean frame after reset
      start_frame(3, 3, {32'h3f80_0000, 32'h4000_0000, 32'h4040_0000}, {32'h4040_0000, 32'h4000_0000, 32'h3f80_0000}, 54, 0);
      wait_frame("done_after_rst");

      repeat (3) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
